// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong score keeper.
package pong_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam logic WINNER_LEFT  = 1'b0;
    localparam logic WINNER_RIGHT = 1'b1;

    typedef logic [3:0] bcd_digit_t;

    // Convert a decimal value 0..99 into packed {tens, units} BCD.
    function automatic logic [7:0] to_bcd2(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with synchronous clear; exposes the next value so the
// caller can compare against a target on the same edge the count updates.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t hi,
    output bcd_digit_t lo,
    output bcd_digit_t nxt_hi,
    output bcd_digit_t nxt_lo
);

    bcd_digit_t hi_q, hi_d;
    bcd_digit_t lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (clr) begin
            hi_d = '0;
            lo_d = '0;
        end else if (inc) begin
            if (lo_q == 4'd9) begin
                lo_d = '0;
                hi_d = (hi_q == 4'd9) ? 4'd0 : hi_q + 4'd1;
            end else begin
                lo_d = lo_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign nxt_hi = hi_d;
    assign nxt_lo = lo_d;

endmodule

// File: rtl/pong_score.sv
// Two-player pong score keeper: edge-detected point inputs, BCD scores,
// win detection and blinking of the winner's digits once the game is over.
module pong_score
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 11,
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       point_l,
    input  logic       point_r,
    output logic [3:0] score_l_hi,
    output logic [3:0] score_l_lo,
    output logic [3:0] score_r_hi,
    output logic [3:0] score_r_lo,
    output logic       game_over,
    output logic       winner,
    output logic       blank_l,
    output logic       blank_r
);

    localparam int unsigned     CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [7:0]       WIN_BCD = to_bcd2(WIN_SCORE);

    state_t           state_q, state_d;
    logic             prev_l_q, prev_r_q;
    logic             game_over_q, game_over_d;
    logic             winner_q, winner_d;
    logic             blank_l_q, blank_l_d;
    logic             blank_r_q, blank_r_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;

    logic       ev_l, ev_r;
    logic       inc_l, inc_r;
    logic       win_l, win_r;
    bcd_digit_t l_hi, l_lo, l_nxt_hi, l_nxt_lo;
    bcd_digit_t r_hi, r_lo, r_nxt_hi, r_nxt_lo;

    assign ev_l  = point_l & ~prev_l_q;
    assign ev_r  = point_r & ~prev_r_q;
    assign inc_l = ev_l & (state_q == PLAY) & ~new_game;
    assign inc_r = ev_r & (state_q == PLAY) & ~new_game;
    assign win_l = inc_l & ({l_nxt_hi, l_nxt_lo} == WIN_BCD);
    assign win_r = inc_r & ({r_nxt_hi, r_nxt_lo} == WIN_BCD);

    bcd2_counter u_cnt_l (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (new_game),
        .inc    (inc_l),
        .hi     (l_hi),
        .lo     (l_lo),
        .nxt_hi (l_nxt_hi),
        .nxt_lo (l_nxt_lo)
    );

    bcd2_counter u_cnt_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (new_game),
        .inc    (inc_r),
        .hi     (r_hi),
        .lo     (r_lo),
        .nxt_hi (r_nxt_hi),
        .nxt_lo (r_nxt_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = PLAY;
        end else if ((state_q == PLAY) && (win_l || win_r)) begin
            state_d = OVER;
        end
    end

    // Left wins a simultaneous finish because its check is taken first.
    always_comb begin
        game_over_d = (state_d == OVER);
        winner_d    = winner_q;
        blank_l_d   = blank_l_q;
        blank_r_d   = blank_r_q;
        blink_cnt_d = '0;
        if (new_game) begin
            winner_d  = WINNER_LEFT;
            blank_l_d = 1'b0;
            blank_r_d = 1'b0;
        end else if (state_q == PLAY) begin
            blank_l_d = 1'b0;
            blank_r_d = 1'b0;
            if (win_l) begin
                winner_d = WINNER_LEFT;
            end else if (win_r) begin
                winner_d = WINNER_RIGHT;
            end
        end else begin
            if (blink_cnt_q == CNT_MAX) begin
                if (winner_q == WINNER_RIGHT) begin
                    blank_r_d = ~blank_r_q;
                end else begin
                    blank_l_d = ~blank_l_q;
                end
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // History resets high so a point input held across reset release is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_l_q    <= 1'b1;
            prev_r_q    <= 1'b1;
            game_over_q <= 1'b0;
            winner_q    <= WINNER_LEFT;
            blank_l_q   <= 1'b0;
            blank_r_q   <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            prev_l_q    <= point_l;
            prev_r_q    <= point_r;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            blank_l_q   <= blank_l_d;
            blank_r_q   <= blank_r_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign score_l_hi = l_hi;
    assign score_l_lo = l_lo;
    assign score_r_hi = r_hi;
    assign score_r_lo = r_lo;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign blank_l    = blank_l_q;
    assign blank_r    = blank_r_q;

endmodule

// File: tb/tb_pong_score.sv
// Directed bench for pong_score: vector table for edge counting plus
// hand-written sequences for carry, win, blink, tie, restart and async reset.
module tb_pong_score;

    logic       clk;
    logic       rst_n;
    logic       new_game;
    logic       point_l;
    logic       point_r;

    logic [3:0] score_l_hi, score_l_lo, score_r_hi, score_r_lo;
    logic       game_over, winner, blank_l, blank_r;

    logic [3:0] d2_l_hi, d2_l_lo, d2_r_hi, d2_r_lo;
    logic       d2_game_over, d2_winner, d2_blank_l, d2_blank_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       ng;
        logic       pl;
        logic       pr;
        logic [3:0] lhi;
        logic [3:0] llo;
    } vec_t;

    vec_t vecs[$];

    pong_score #(.WIN_SCORE(11), .BLINK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .point_l    (point_l),
        .point_r    (point_r),
        .score_l_hi (score_l_hi),
        .score_l_lo (score_l_lo),
        .score_r_hi (score_r_hi),
        .score_r_lo (score_r_lo),
        .game_over  (game_over),
        .winner     (winner),
        .blank_l    (blank_l),
        .blank_r    (blank_r)
    );

    // Second instance with an unreachable win score so the carry past 11 can be seen.
    pong_score #(.WIN_SCORE(99), .BLINK_DIV(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .point_l    (point_l),
        .point_r    (point_r),
        .score_l_hi (d2_l_hi),
        .score_l_lo (d2_l_lo),
        .score_r_hi (d2_r_hi),
        .score_r_lo (d2_r_lo),
        .game_over  (d2_game_over),
        .winner     (d2_winner),
        .blank_l    (d2_blank_l),
        .blank_r    (d2_blank_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] tens(input int v);
        return 4'(v / 10);
    endfunction

    function automatic logic [3:0] units(input int v);
        return 4'(v % 10);
    endfunction

    function automatic void pushVec(input string name, input logic ng, input logic pl,
                                    input logic pr, input int l);
        vec_t v;
        v.name = name;
        v.ng   = ng;
        v.pl   = pl;
        v.pr   = pr;
        v.lhi  = tens(l);
        v.llo  = units(l);
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic ng, input logic pl, input logic pr);
        @(negedge clk);
        new_game = ng;
        point_l  = pl;
        point_r  = pr;
        @(posedge clk);
        #1;
    endtask

    // Packed as {l_hi, l_lo, r_hi, r_lo, game_over, winner, blank_l, blank_r}.
    task automatic checkOutput(input string name, input int l, input int r,
                               input logic go, input logic win,
                               input logic bl, input logic br);
        logic [19:0] act;
        logic [19:0] exp;
        act = {score_l_hi, score_l_lo, score_r_hi, score_r_lo, game_over, winner, blank_l, blank_r};
        exp = {tens(l), units(l), tens(r), units(r), go, win, bl, br};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (L/R digits, then go,win,bl,br bits)",
                     name, act, exp);
        end
    endtask

    task automatic checkDut2(input string name, input int l, input int r);
        logic [15:0] act;
        logic [15:0] exp;
        act = {d2_l_hi, d2_l_lo, d2_r_hi, d2_r_lo};
        exp = {tens(l), units(l), tens(r), units(r)};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        int ri;
        int k;
        logic bl_exp;
        logic br_exp;
        logic pr_bit;

        new_game = 1'b0;
        point_l  = 1'b1;
        point_r  = 1'b0;
        rst_n    = 1'b1;
        #1;
        rst_n    = 1'b0;

        // Reset with point_l high; holding it across release must not score.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_values", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("held_across_reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Three short pulses then one ten-cycle pulse on the left.
        pushVec("drop_l",   1'b0, 1'b0, 1'b0, 0);
        pushVec("pulse1",   1'b0, 1'b1, 1'b0, 1);
        pushVec("gap1",     1'b0, 1'b0, 1'b0, 1);
        pushVec("pulse2",   1'b0, 1'b1, 1'b0, 2);
        pushVec("gap2",     1'b0, 1'b0, 1'b0, 2);
        pushVec("pulse3",   1'b0, 1'b1, 1'b0, 3);
        pushVec("gap3",     1'b0, 1'b0, 1'b0, 3);
        for (int i = 0; i < 10; i++) pushVec("long_pulse", 1'b0, 1'b1, 1'b0, 4);
        pushVec("long_end", 1'b0, 1'b0, 1'b0, 4);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ng, vecs[i].pl, vecs[i].pr);
            checkOutput(vecs[i].name, (vecs[i].lhi * 10) + vecs[i].llo, 0,
                        1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Right side: 19 pulses. Main instance wins at 11 and freezes; dut2 carries to 19.
        for (int i = 1; i <= 19; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                pr_bit = (ph == 0);
                applyStimulus(1'b0, 1'b0, pr_bit);
                ri = (i < 11) ? i : 11;
                k  = 2 * (i - 11) + ph;
                br_exp = (i >= 11) ? 1'((k / 4) % 2) : 1'b0;
                checkOutput("right_count", 4, ri, (i >= 11), (i >= 11), 1'b0, br_exp);
                checkDut2("carry_dut2", 4, i);
            end
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("new_game_after_right_win", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkDut2("new_game_dut2", 0, 0);

        // Left reaches 11; game_over appears with the final score.
        for (int i = 1; i <= 11; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("left_to_win", i, 0, (i == 11), 1'b0, 1'b0, 1'b0);
            if (i < 11) applyStimulus(1'b0, 1'b0, 1'b0);
        end

        // Blinking on the left; right pulses are ignored while over.
        for (int kk = 1; kk <= 8; kk++) begin
            pr_bit = (kk == 2) || (kk == 5);
            applyStimulus(1'b0, 1'b0, pr_bit);
            bl_exp = 1'((kk / 4) % 2);
            checkOutput("blink_left", 11, 0, 1'b1, 1'b0, bl_exp, 1'b0);
        end

        // new_game together with a point_l edge: cleared, and that edge is lost.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("restart_with_edge", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("edge_lost", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Both sides rise together up to 11-11; left takes the tie.
        for (int i = 1; i <= 11; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("tie_climb", i, i, (i == 11), 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("tie_gap", i, i, (i == 11), 1'b0, 1'b0, 1'b0);
        end

        // Async reset in the middle of a game.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("before_async_reset", 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkDut2("async_reset_dut2", 0, 0);
        point_l = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("count_after_reset", 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
